imm_gen_pipe: RTL and testbench

//   Registered, elastic RISC-V immediate generator for the decode stage.
//   - Accepts one 32-bit instruction per cycle over a valid/ready handshake.
//   - Emits the sign- or zero-extended XLEN-bit immediate, an immediate-type code and an illegal flag.
//   - Adds shamt and CSR-zimm formats, RV64 support and a saturating illegal-opcode counter.
//   - Replaces the combinational immediate generator between fetch and the decode/issue register.

---
 rtl/imm_gen_pipe_if.sv | 36 +++
 rtl/imm_gen_pipe.sv | 132 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Decode-stage handshake bundle for the immediate generator.
// Instruction in on one side, immediate/type/illegal out on the other.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic            out_illegal;

  modport master (
    output in_valid,
    output in_inst,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_imm,
    input  out_type,
    input  out_illegal
  );

  modport slave (
    input  in_valid,
    input  in_inst,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_imm,
    output out_type,
    output out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a one-entry skid buffer.
// Emits immediate, format code and illegal flag; counts illegal opcodes.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_gen_pipe_if.slave    bus,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            ill;
  } res_t;

  logic [31:0] i;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        sh_f3;
  logic        t_i, t_sh, t_s, t_b;
  logic        t_u, t_j, t_csr, t_r;
  res_t        dec;

  assign i     = bus.in_inst;
  assign op    = i[6:0];
  assign f3    = i[14:12];
  assign sh_f3 = (f3 == 3'b001) || (f3 == 3'b101);

  assign t_i = (op == 7'b0000011)
            || (op == 7'b1100111)
            || (op == 7'b0001111)
            || (op == 7'b0010011 && !sh_f3)
            || (RV64 && op == 7'b0011011 && !sh_f3)
            || (op == 7'b1110011 && !f3[2]);
  assign t_sh = (op == 7'b0010011 && sh_f3)
             || (RV64 && op == 7'b0011011 && sh_f3);
  assign t_s   = (op == 7'b0100011);
  assign t_b   = (op == 7'b1100011);
  assign t_u   = (op == 7'b0110111) || (op == 7'b0010111);
  assign t_j   = (op == 7'b1101111);
  assign t_csr = (op == 7'b1110011) && f3[2];
  assign t_r   = (op == 7'b0110011)
              || (RV64 && op == 7'b0111011);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      t_i: begin
        dec.typ = 3'd1;
        dec.imm = XLEN'($signed(i[31:20]));
      end
      t_s: begin
        dec.typ = 3'd2;
        dec.imm = XLEN'($signed({i[31:25], i[11:7]}));
      end
      t_b: begin
        dec.typ = 3'd3;
        dec.imm = XLEN'($signed({i[31], i[7],
                  i[30:25], i[11:8], 1'b0}));
      end
      t_u: begin
        dec.typ = 3'd4;
        dec.imm = XLEN'($signed({i[31:12], 12'b0}));
      end
      t_j: begin
        dec.typ = 3'd5;
        dec.imm = XLEN'($signed({i[31], i[19:12],
                  i[20], i[30:21], 1'b0}));
      end
      t_csr: begin
        dec.typ = 3'd6;
        dec.imm = XLEN'(i[19:15]);
      end
      // Word shifts (0011011) keep a 5-bit shamt even on RV64
      t_sh: begin
        dec.typ = 3'd7;
        dec.imm = (RV64 && op == 7'b0010011)
                ? XLEN'(i[25:20])
                : XLEN'(i[24:20]);
      end
      t_r: dec.typ = 3'd0;
      default: dec.ill = 1'b1;
    endcase
  end

  res_t out_q;
  res_t skid_q;
  logic out_v;
  logic skid_v;
  logic acc;
  logic xfer;

  assign acc  = bus.in_valid && !skid_v;
  assign xfer = out_v && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_v       <= 1'b0;
      skid_v      <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      illegal_cnt <= '0;
    end else begin
      if (xfer && skid_v) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end else if (acc && (xfer || !out_v)) begin
        out_q <= dec;
        out_v <= 1'b1;
      end else if (acc) begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end else if (xfer) begin
        out_v <= 1'b0;
      end
      if (acc && dec.ill && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready    = !skid_v;
  assign bus.out_valid   = out_v;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_type    = out_q.typ;
  assign bus.out_illegal = out_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32/CNT_W=2 and RV64 instances driven in lockstep,
// expected results queued at accept and popped by a monitor at transfer.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [1:0]  cnt_a;
  logic [7:0]  cnt_b;

  imm_gen_pipe_if #(.XLEN(32)) ia ();
  imm_gen_pipe_if #(.XLEN(64)) ib ();

  assign ia.in_valid  = in_valid;
  assign ia.in_inst   = in_inst;
  assign ia.out_ready = out_ready;
  assign ib.in_valid  = in_valid;
  assign ib.in_inst   = in_inst;
  assign ib.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .illegal_cnt(cnt_a));
  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .illegal_cnt(cnt_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  t32;
    logic [2:0]  t64;
    logic        il32;
    logic        il64;
  } exp_t;

  exp_t q[$];
  int   vec = 0;
  int   miss = 0;
  int   pend = 0;
  int   mcnt_a = 0;
  int   mcnt_b = 0;
  bit   rnd_rdy = 0;

  function automatic void chk(input string nm,
                              input logic [63:0] got,
                              input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endfunction

  function automatic longint bits(input logic [31:0] x,
                                  input int lo, input int n);
    logic [31:0] m;
    m = (x >> lo) & ((32'd1 << n) - 32'd1);
    return longint'(m);
  endfunction

  // Reference: immediates as signed integers built from field weights
  function automatic void model(input logic [31:0] x, input int xl,
                                output logic [63:0] imm,
                                output logic [2:0] t,
                                output logic il);
    longint si, sg, v;
    int     op, f3;
    bit     sh;
    si = longint'($signed(x));
    sg = si >>> 63;
    op = int'(x[6:0]);
    f3 = int'(x[14:12]);
    sh = (f3 == 1) || (f3 == 5);
    v = 0; t = 0; il = 0;
    case (op)
      'h03, 'h67, 'h0F: begin t = 1; v = si >>> 20; end
      'h13:
        if (sh) begin t = 7; v = bits(x, 20, (xl == 64) ? 6 : 5); end
        else begin t = 1; v = si >>> 20; end
      'h1B:
        if (xl != 64) il = 1;
        else if (sh) begin t = 7; v = bits(x, 20, 5); end
        else begin t = 1; v = si >>> 20; end
      'h23: begin t = 2; v = (si >>> 25) * 32 + bits(x, 7, 5); end
      'h63: begin
        t = 3;
        v = sg * 4096 + bits(x, 7, 1) * 2048
          + bits(x, 25, 6) * 32 + bits(x, 8, 4) * 2;
      end
      'h37, 'h17: begin t = 4; v = si - bits(x, 0, 12); end
      'h6F: begin
        t = 5;
        v = sg * 1048576 + bits(x, 12, 8) * 4096
          + bits(x, 20, 1) * 2048 + bits(x, 21, 10) * 2;
      end
      'h73:
        if (x[14]) begin t = 6; v = bits(x, 15, 5); end
        else begin t = 1; v = si >>> 20; end
      'h33: ;
      'h3B: if (xl != 64) il = 1;
      default: il = 1;
    endcase
    imm = (xl == 32) ? {32'b0, v[31:0]} : 64'(v);
  endfunction

  function automatic exp_t mk(input logic [31:0] x);
    exp_t e;
    e.inst = x;
    model(x, 32, e.imm32, e.t32, e.il32);
    model(x, 64, e.imm64, e.t64, e.il64);
    return e;
  endfunction

  // Accept tracker: handshake/counter checks and scoreboard push
  always @(negedge clk) begin
    exp_t e;
    pend = 0;
    if (rst_n) begin
      chk("in_ready_a", 64'(ia.in_ready), 64'(q.size() < 2));
      chk("in_ready_b", 64'(ib.in_ready), 64'(q.size() < 2));
      chk("cnt_a", 64'(cnt_a), 64'(mcnt_a));
      chk("cnt_b", 64'(cnt_b), 64'(mcnt_b));
      if (in_valid && ia.in_ready) begin
        e = mk(in_inst);
        q.push_back(e);
        pend = 1;
        if (e.il32 && mcnt_a < 3) mcnt_a++;
        if (e.il64 && mcnt_b < 255) mcnt_b++;
      end
    end
  end

  // Monitor: compare the presented result with the oldest expected one
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst_n) begin
      chk("out_valid_a", 64'(ia.out_valid), 64'(q.size() > pend));
      chk("out_valid_b", 64'(ib.out_valid), 64'(q.size() > pend));
      if (ia.out_valid && q.size() > 0) begin
        e = q[0];
        chk("imm_a", {32'b0, ia.out_imm}, e.imm32);
        chk("type_a", 64'(ia.out_type), 64'(e.t32));
        chk("ill_a", 64'(ia.out_illegal), 64'(e.il32));
        chk("imm_b", ib.out_imm, e.imm64);
        chk("type_b", 64'(ib.out_type), 64'(e.t64));
        chk("ill_b", 64'(ib.out_illegal), 64'(e.il64));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] x);
    bit ok;
    ok = 0;
    in_inst  = x;
    in_valid = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = rst_n && ia.in_ready;
      step();
    end
    chk("accept", 64'(ok), 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && q.size() > 0; k++) step();
    chk("drain", 64'(q.size()), 64'd0);
    step();
  endtask

  task automatic rst_seq();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    mcnt_a = 0;
    mcnt_b = 0;
    @(negedge clk);
    chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
    chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
    chk("rst_cnt_a", 64'(cnt_a), 64'd0);
    chk("rst_imm_b", ib.out_imm, 64'd0);
    chk("rst_type_a", 64'(ia.out_type), 64'd0);
    chk("rst_ill_b", 64'(ib.out_illegal), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] sweep [5] = '{32'h8010_0093, 32'hFEA0_8CE3,
                             32'h0000_12B7, 32'h4050_D093,
                             32'h3400_D073};
  logic [31:0] rv64v [3] = '{32'h03F0_9093, 32'h8000_00B7,
                             32'h0010_809B};
  logic [6:0]  ops [18] = '{7'h03, 7'h67, 7'h0F, 7'h13, 7'h13,
                            7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
                            7'h6F, 7'h73, 7'h73, 7'h33, 7'h3B,
                            7'h7F, 7'h00, 7'h5B};

  initial begin
    logic [31:0] r;
    // Reset with in_valid held high; first accept follows release
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = sweep[0];
    rst_seq();
    foreach (sweep[k]) send(sweep[k]);
    foreach (rv64v[k]) send(rv64v[k]);
    drain();

    // Backpressure: two fit, the third waits on in_ready
    out_ready = 1'b0;
    send(32'h0000_0513);
    send(32'h0080_0A23);
    in_inst  = 32'hFFF0_0F6F;
    in_valid = 1'b1;
    repeat (4) step();
    out_ready = 1'b1;
    send(32'hFFF0_0F6F);
    send(32'h0010_0317);
    drain();

    // Illegal opcodes, saturating the 2-bit counter
    repeat (5) send(32'h0000_007F);
    send(32'h0020_809B);
    send(32'h0000_001B);
    drain();

    // Random traffic with random backpressure
    rnd_rdy = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 17)];
        send(r);
      end
    end
    rnd_rdy = 0;
    drain();

    // Reset with the skid full: held entries must vanish
    out_ready = 1'b0;
    send(32'h1230_0093);
    send(32'h0000_007F);
    in_valid = 1'b0;
    rst_seq();
    out_ready = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
